// File: rtl/ball_bounce_renderer_pkg.sv
// rtl/ball_bounce_renderer_pkg.sv - shared display constants and bounce direction encoding
`timescale 1ns/1ps

package ball_bounce_renderer_pkg;

  // Default visible area, shared with the sync generator and test pattern top
  localparam int H_DISPLAY_DEF = 256;
  localparam int V_DISPLAY_DEF = 240;

  // Per-axis travel direction
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

endpackage

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - single-axis ball position and direction state machine
`timescale 1ns/1ps

module bounce_axis
  import ball_bounce_renderer_pkg::*;
#(
  parameter int MAX   = 248,
  parameter int SPEED = 1,
  parameter int INIT  = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [8:0] pos,
  output logic       bounce
);

  localparam logic [9:0] MAX_W   = 10'(MAX);
  localparam logic [9:0] SPEED_W = 10'(SPEED);

  dir_e       dir;
  dir_e       dir_next;
  logic [8:0] pos_next;
  logic [9:0] pos_ext;
  logic [9:0] sum;

  assign pos_ext = {1'b0, pos};
  assign sum     = pos_ext + SPEED_W;

  // Next position/direction; 10-bit sums clamp at the walls instead of wrapping
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    bounce   = 1'b0;
    if (step) begin
      if (dir == DIR_INC) begin
        if (sum >= MAX_W) begin
          pos_next = MAX_W[8:0];
          dir_next = DIR_DEC;
          bounce   = 1'b1;
        end else begin
          pos_next = sum[8:0];
        end
      end else begin
        if (pos_ext <= SPEED_W) begin
          pos_next = 9'd0;
          dir_next = DIR_INC;
          bounce   = 1'b1;
        end else begin
          pos_next = pos - SPEED_W[8:0];
        end
      end
    end
  end

  // Position and direction registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pos <= 9'(INIT);
      dir <= DIR_INC;
    end else begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/ball_bounce_renderer.sv
// rtl/ball_bounce_renderer.sv - bouncing ball over a grid pattern with registered video outputs
`timescale 1ns/1ps

module ball_bounce_renderer
  import ball_bounce_renderer_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int BALL_SIZE = 8,
  parameter int SPEED     = 1,
  parameter int INIT_X    = 128,
  parameter int INIT_Y    = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       display_on,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [2:0] rgb,
  output logic       hit
);

  localparam int         MAX_X  = H_DISPLAY - BALL_SIZE;
  localparam int         MAX_Y  = V_DISPLAY - BALL_SIZE;
  localparam logic [9:0] SIZE_W = 10'(BALL_SIZE);

  logic       vsync_d;
  logic       tick;
  logic       step;
  logic [8:0] ball_x;
  logic [8:0] ball_y;
  logic       bounce_x;
  logic       bounce_y;
  logic       in_x;
  logic       in_y;
  logic [2:0] background;
  logic [2:0] pixel;

  // Frame tick on vsync rising edge; position only moves here so a frame never tears
  assign tick = vsync & ~vsync_d;
  assign step = tick & enable;

  bounce_axis #(.MAX(MAX_X), .SPEED(SPEED), .INIT(INIT_X)) u_axis_x (
    .clk    (clk),
    .reset  (reset),
    .step   (step),
    .pos    (ball_x),
    .bounce (bounce_x)
  );

  bounce_axis #(.MAX(MAX_Y), .SPEED(SPEED), .INIT(INIT_Y)) u_axis_y (
    .clk    (clk),
    .reset  (reset),
    .step   (step),
    .pos    (ball_y),
    .bounce (bounce_y)
  );

  // Ball window test and background grid colour for the current pixel
  always_comb begin
    in_x       = ({1'b0, hpos} >= {1'b0, ball_x}) && ({1'b0, hpos} < ({1'b0, ball_x} + SIZE_W));
    in_y       = ({1'b0, vpos} >= {1'b0, ball_y}) && ({1'b0, vpos} < ({1'b0, ball_y} + SIZE_W));
    background = {(hpos[2:0] == 3'd0) || (vpos[2:0] == 3'd0), vpos[4], hpos[4]};
    pixel      = 3'b000;
    if (display_on) begin
      pixel = (in_x && in_y) ? 3'b111 : background;
    end
  end

  // One-cycle video pipeline, vsync edge history and bounce pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_d <= 1'b0;
      rgb     <= 3'b000;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      hit     <= 1'b0;
    end else begin
      vsync_d <= vsync;
      rgb     <= pixel;
      hsync_o <= hsync;
      vsync_o <= vsync;
      hit     <= bounce_x | bounce_y;
    end
  end

endmodule

// File: tb/tb_ball_bounce_renderer.sv
// tb/tb_ball_bounce_renderer.sv - self-checking bench for ball_bounce_renderer
`timescale 1ns/1ps

module tb_ball_bounce_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       enable_c = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic       display_on = 1'b0;
  logic [8:0] hpos = 9'd0;
  logic [8:0] vpos = 9'd0;
  logic       hsync_o, vsync_o, hit;
  logic [2:0] rgb;
  logic       hsync_o_c, vsync_o_c, hit_c;
  logic [2:0] rgb_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_bounce_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .rgb        (rgb),
    .hit        (hit)
  );

  ball_bounce_renderer #(.INIT_X(240), .INIT_Y(224)) dut_c (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable_c),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync_o    (hsync_o_c),
    .vsync_o    (vsync_o_c),
    .rgb        (rgb_c),
    .hit        (hit_c)
  );

  typedef struct {
    logic [8:0] hp;
    logic [8:0] vp;
    logic       de;
    logic       hs;
    logic       vs;
    logic [2:0] e_rgb;
    logic       e_hs;
    logic       e_vs;
  } vec_t;

  typedef struct {
    logic [2:0] e_rgb;
    logic       e_hs;
    logic       e_vs;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  logic [8:0] mx, my, mcx, mcy;
  logic       mdx, mdy, mdcx, mdcy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] bg(input logic [8:0] h, input logic [8:0] v);
    return {(h[2:0] == 3'd0) || (v[2:0] == 3'd0), v[4], h[4]};
  endfunction

  // returns {bounce, dir, pos}
  function automatic logic [10:0] next_axis(input logic [8:0] p, input logic d, input int lim);
    logic [10:0] r;
    if (!d) begin
      if (int'(p) + 1 >= lim) r = {1'b1, 1'b1, 9'(lim)};
      else                    r = {1'b0, 1'b0, p + 9'd1};
    end else begin
      if (p <= 9'd1) r = {1'b1, 1'b0, 9'd0};
      else           r = {1'b0, 1'b1, p - 9'd1};
    end
    return r;
  endfunction

  task automatic drive(input logic [8:0] hp, input logic [8:0] vp, input logic de,
                       input logic hs, input logic vs,
                       input logic [2:0] e_rgb, input logic e_hs, input logic e_vs);
    exp_t e;
    @(negedge clk);
    hpos = hp; vpos = vp; display_on = de; hsync = hs; vsync = vs;
    sb.push_back('{e_rgb, e_hs, e_vs});
    @(posedge clk); #1;
    e = sb.pop_front();
    check("rgb", 32'(rgb), 32'(e.e_rgb));
    check("hsync_o", 32'(hsync_o), 32'(e.e_hs));
    check("vsync_o", 32'(vsync_o), 32'(e.e_vs));
  endtask

  task automatic do_tick(input logic e_hit, input logic e_hit_c);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(posedge clk); #1;
    check("hit_tick", 32'(hit), 32'(e_hit));
    check("hit_c_tick", 32'(hit_c), 32'(e_hit_c));
    @(posedge clk); #1;
    check("hit_after", 32'(hit), 32'd0);
    check("hit_c_after", 32'(hit_c), 32'd0);
  endtask

  task automatic tick_all();
    logic [10:0] r;
    logic bm, bc;
    bm = 1'b0;
    bc = 1'b0;
    if (enable) begin
      r = next_axis(mx, mdx, 248); mx = r[8:0]; mdx = r[9]; bm = r[10];
      r = next_axis(my, mdy, 232); my = r[8:0]; mdy = r[9]; bm = bm | r[10];
    end
    if (enable_c) begin
      r = next_axis(mcx, mdcx, 248); mcx = r[8:0]; mdcx = r[9]; bc = r[10];
      r = next_axis(mcy, mdcy, 232); mcy = r[8:0]; mdcy = r[9]; bc = bc | r[10];
    end
    do_tick(bm, bc);
  endtask

  task automatic check_pos();
    check("ball_x", 32'(dut.ball_x), 32'(mx));
    check("ball_y", 32'(dut.ball_y), 32'(my));
    check("dir_x", 32'(dut.u_axis_x.dir), 32'(mdx));
    check("dir_y", 32'(dut.u_axis_y.dir), 32'(mdy));
  endtask

  task automatic check_pos_c();
    check("c_ball_x", 32'(dut_c.ball_x), 32'(mcx));
    check("c_ball_y", 32'(dut_c.ball_y), 32'(mcy));
    check("c_dir_x", 32'(dut_c.u_axis_x.dir), 32'(mdcx));
    check("c_dir_y", 32'(dut_c.u_axis_y.dir), 32'(mdcy));
  endtask

  initial begin
    vecs[0]  = '{9'd128, 9'd120, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[1]  = '{9'd135, 9'd127, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[2]  = '{9'd136, 9'd120, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0};
    vecs[3]  = '{9'd127, 9'd119, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0};
    vecs[4]  = '{9'd128, 9'd128, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0};
    vecs[5]  = '{9'd128, 9'd119, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0};
    vecs[6]  = '{9'd135, 9'd128, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0};
    vecs[7]  = '{9'd17,  9'd33,  1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[8]  = '{9'd19,  9'd21,  1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0};
    vecs[9]  = '{9'd255, 9'd239, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[10] = '{9'd128, 9'd120, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[11] = '{9'd5,   9'd6,   1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0};
    vecs[12] = '{9'd3,   9'd3,   1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
    vecs[13] = '{9'd0,   9'd0,   1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0};

    mx = 9'd128; my = 9'd120; mdx = 1'b0; mdy = 1'b0;
    mcx = 9'd240; mcy = 9'd224; mdcx = 1'b0; mdcy = 1'b0;

    // Reset with busy inputs: outputs must still be cleared
    reset = 1'b0; hsync = 1'b1; vsync = 1'b1; display_on = 1'b1;
    hpos = 9'd128; vpos = 9'd120;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hsync_o", 32'(hsync_o), 32'd0);
    check("rst_vsync_o", 32'(vsync_o), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check_pos();
    @(negedge clk);
    hsync = 1'b0; vsync = 1'b0;
    reset = 1'b1;

    // Rendering table with motion disabled
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].hp, vecs[i].vp, vecs[i].de, vecs[i].hs, vecs[i].vs,
            vecs[i].e_rgb, vecs[i].e_hs, vecs[i].e_vs);
    end
    check_pos();

    // Frozen across three ticks
    enable = 1'b0;
    repeat (3) tick_all();
    check_pos();
    check("freeze_x", 32'(dut.ball_x), 32'd128);

    // Walk ball_x to 247 heading right, then bounce off the right wall
    enable = 1'b1;
    repeat (119) tick_all();
    check_pos();
    check("pre_x", 32'(dut.ball_x), 32'd247);
    check("pre_dir", 32'(dut.u_axis_x.dir), 32'd0);
    tick_all();
    check_pos();
    check("wall_x", 32'(dut.ball_x), 32'd248);
    check("wall_dir", 32'(dut.u_axis_x.dir), 32'd1);
    tick_all();
    check_pos();
    check("back_x", 32'(dut.ball_x), 32'd247);

    // New position shows up in the rendered frame
    drive(mx, my, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1);
    drive(mx + 9'd8, my, 1'b1, 1'b0, 1'b1, bg(mx + 9'd8, my), 1'b0, 1'b1);
    drive(mx, my + 9'd8, 1'b1, 1'b0, 1'b1, bg(mx, my + 9'd8), 1'b0, 1'b1);

    // Mid-frame reset with vsync held high: first tick is the first edge after release
    @(negedge clk);
    hpos = mx; vpos = my; display_on = 1'b1; vsync = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    mx = 9'd128; my = 9'd120; mdx = 1'b0; mdy = 1'b0;
    check_pos();
    check("mrst_rgb", 32'(rgb), 32'd0);
    check("mrst_hit", 32'(hit), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    mx = 9'd129; my = 9'd121;
    check_pos();
    check("rel_hit", 32'(hit), 32'd0);
    @(posedge clk); #1;
    check_pos();
    check_pos_c();

    // Corner bounce on the second instance
    enable = 1'b0;
    enable_c = 1'b1;
    repeat (7) tick_all();
    check_pos_c();
    check("corner_pre_x", 32'(dut_c.ball_x), 32'd247);
    check("corner_pre_y", 32'(dut_c.ball_y), 32'd231);
    tick_all();
    check_pos_c();
    check("corner_x", 32'(dut_c.ball_x), 32'd248);
    check("corner_y", 32'(dut_c.ball_y), 32'd232);
    check("corner_dx", 32'(dut_c.u_axis_x.dir), 32'd1);
    check("corner_dy", 32'(dut_c.u_axis_y.dir), 32'd1);
    check_pos();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_bounce_renderer.md
BALL_BOUNCE_RENDERER -- requirements
Module: ball_bounce_renderer

Interface
REQ-001 Parameters SHALL be:
  - H_DISPLAY, 256: visible pixels per line.
  - V_DISPLAY, 240: visible lines per frame.
  - BALL_SIZE, 8: ball edge length in pixels; power of two, at most 16.
  - SPEED, 1: pixels moved per axis per frame; 1 <= SPEED < BALL_SIZE.
  - INIT_X, 128: ball left edge after reset.
  - INIT_Y, 120: ball top edge after reset.
REQ-002 Ports SHALL be (clock and reset first):
  - clk, in, 1: system/pixel clock.
  - reset, in, 1: synchronous, active-low reset.
  - enable, in, 1: allows ball motion when high.
  - hsync, in, 1: horizontal sync from the upstream sync generator.
  - vsync, in, 1: vertical sync from the upstream sync generator.
  - display_on, in, 1: high inside the visible area.
  - hpos, in, 9: horizontal pixel position.
  - vpos, in, 9: vertical pixel position.
  - hsync_o, out, 1: hsync delayed to match rgb.
  - vsync_o, out, 1: vsync delayed to match rgb.
  - rgb, out, 3: pixel colour, BGR order.
  - hit, out, 1: one-cycle pulse on any wall bounce.
REQ-003 There SHALL be exactly one clock, clk; reset SHALL be synchronous and active-low, and all flops SHALL be in the clk domain.

Function
REQ-004 rgb, hsync_o and vsync_o SHALL be registered with exactly 1-cycle latency from hpos, vpos, display_on, hsync and vsync.
REQ-005 rgb SHALL be 3'b000 whenever the registered display_on is low.
REQ-006 Ball pixel: hpos is in [ball_x, ball_x+BALL_SIZE-1] and vpos is in [ball_y, ball_y+BALL_SIZE-1]; the ball pixel SHALL output rgb=3'b111.
REQ-007 Background pixel SHALL output:
  - rgb[2] = (hpos[2:0]==0) | (vpos[2:0]==0), the grid;
  - rgb[1] = vpos[4];
  - rgb[0] = hpos[4].
REQ-008 A frame tick SHALL be the rising edge of vsync, detected against a 1-cycle delayed copy; it SHALL be exactly one cycle long per frame.
REQ-009 The ball position (ball_x, ball_y, 9 bit each) SHALL update only on a frame tick with enable high, and SHALL hold otherwise.
REQ-010 Each axis SHALL run a 2-state FSM, INC or DEC:
  - INC: the next position is pos+SPEED. If that is >= MAX, pos SHALL become MAX, the state SHALL go to DEC, and a bounce SHALL be flagged.
  - DEC: if pos <= SPEED, pos SHALL become 0, the state SHALL go to INC, and a bounce SHALL be flagged; otherwise pos SHALL become pos-SPEED.
  - MAX_X = H_DISPLAY-BALL_SIZE; MAX_Y = V_DISPLAY-BALL_SIZE.
REQ-011 Position arithmetic SHALL use 10-bit intermediates with no wrap-around; the position SHALL never leave [0, MAX].
REQ-012 hit SHALL pulse high for exactly one cycle, the cycle after a tick in which either axis bounced; a simultaneous X and Y bounce (corner) SHALL produce a single pulse with both directions reversed.
REQ-013 A position update SHALL take effect from the next frame; no mid-frame tearing is permitted because updates occur only at the vsync rising edge.
REQ-014 enable low SHALL freeze position and direction state; rendering SHALL continue.

Reset
REQ-015 While reset==0 at a clk edge, the registers SHALL take these values:
  - ball_x=INIT_X, ball_y=INIT_Y;
  - both axis FSMs = INC;
  - rgb=0, hsync_o=0, vsync_o=0, hit=0;
  - the vsync delay flop = 0.
REQ-016 A reset asserted mid-frame SHALL take effect on the next edge, and the first tick after release SHALL be the first vsync rising edge seen with the delay flop at 0.

Structure
REQ-017 The shared package SHALL hold the default H_DISPLAY and V_DISPLAY constants and the INC/DEC direction encoding, shared with the sync generator and the test pattern top.
REQ-018 One sub-module SHALL exist: bounce_axis, a single-axis position/direction FSM parameterised by MAX and SPEED, instantiated twice; the colour/pipeline logic SHALL stay in the top.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - Reset, then hpos=INIT_X, vpos=INIT_Y, display_on=1 -> the next cycle gives rgb=3'b111.
  - display_on=0 with any hpos/vpos -> the next cycle gives rgb=0; hsync/vsync pulses appear on hsync_o/vsync_o exactly 1 cycle later.
  - Move ball_x to 247 with dir INC, SPEED=1, then one tick -> ball_x=248, state DEC, hit pulses once; next tick -> ball_x=247, no hit.
  - Corner: ball at (247,231) with both axes INC, then one tick -> ball at (248,232), both DEC, a single 1-cycle hit.
  - enable=0 across 3 ticks -> ball position and state unchanged, hit=0.
  - Reset asserted mid-frame with ball at (10,10) -> next edge gives ball=(128,120), rgb=0, hit=0.
